// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU with a one-entry result slot.
// Build option: define ALU_ARB_RR_EN for round-robin tie-break, else requester 0 has fixed priority.

`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd2
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'd3
`endif

module alu_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CTL_W = `ALU_CTL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_ctl,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    output logic [CTL_W-1:0] alu_ctl,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    input  logic [XLEN-1:0]  alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_result
);

    logic            w_slot_free;
    logic            w_pick1;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_grant;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [XLEN-1:0] r_rsp_result;

    // Slot can be refilled in the same cycle the consumer drains it.
    assign w_slot_free = ~r_rsp_valid | rsp_ready;

`ifdef ALU_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_grant1;
        end
    end

    // On a tie the requester that was not granted last wins.
    assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);
`else
    assign w_pick1 = req1_valid & ~req0_valid;
`endif

    assign w_grant0 = ~rst & w_slot_free & req0_valid & ~w_pick1;
    assign w_grant1 = ~rst & w_slot_free & w_pick1;
    assign w_grant  = w_grant0 | w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        alu_ctl = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (w_grant1) begin
            alu_ctl = req1_ctl;
            alu_a   = req1_a;
            alu_b   = req1_b;
        end else if (w_grant0) begin
            alu_ctl = req0_ctl;
            alu_a   = req0_a;
            alu_b   = req0_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
        end else if (w_grant) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_grant1;
            r_rsp_result <= alu_result;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; supplies a small reference ALU on the alu_* port.
// Expectations follow the ALU_ARB_RR_EN setting of the build.

`ifndef ALU_CTL_WIDTH
`define ALU_CTL_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd2
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'd3
`endif

module tb_alu_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CTL_W = `ALU_CTL_WIDTH;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [CTL_W-1:0] req0_ctl;
    logic [XLEN-1:0]  req0_a;
    logic [XLEN-1:0]  req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [CTL_W-1:0] req1_ctl;
    logic [XLEN-1:0]  req1_a;
    logic [XLEN-1:0]  req1_b;
    logic [CTL_W-1:0] alu_ctl;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [XLEN-1:0]  alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [XLEN-1:0]  rsp_result;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(
        .XLEN  (XLEN),
        .CTL_W (CTL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctl   (req0_ctl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctl   (req1_ctl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_ctl    (alu_ctl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    // Reference ALU standing in for the shared datapath.
    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            `ALU_ADD: alu_result = alu_a + alu_b;
            `ALU_SUB: alu_result = alu_a - alu_b;
            `ALU_SLL: alu_result = alu_a << alu_b[4:0];
            `ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default:  alu_result = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_w;
        bit rr;
`ifdef ALU_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_ctl   = `ALU_ADD;
        req0_a     = 32'd1;
        req0_b     = 32'd1;
        req1_ctl   = `ALU_ADD;
        req1_a     = 32'd2;
        req1_b     = 32'd2;
        rsp_ready  = 1'b1;

        // Reset state: outputs clear and no grant despite both valid.
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);

        // req0 only, ADD 5+7, granted in the first cycle after reset.
        rst        = 1'b0;
        req1_valid = 1'b0;
        req0_ctl   = `ALU_ADD;
        req0_a     = 32'd5;
        req0_b     = 32'd7;
        #1;
        check("add_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("add_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        step();
        check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("add_rsp_result", rsp_result, 32'd12);

        // Back-to-back SLL 1<<4 then SLT -1<0, no bubble.
        req0_ctl = `ALU_SLL;
        req0_a   = 32'd1;
        req0_b   = 32'd4;
        #1;
        check("sll_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        check("sll_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("sll_rsp_result", rsp_result, 32'd16);
        req0_ctl = `ALU_SLT;
        req0_a   = 32'hFFFF_FFFF;
        req0_b   = 32'd0;
        #1;
        check("slt_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        check("slt_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("slt_rsp_result", rsp_result, 32'd1);

        // req1 SUB 3-10, then back-pressure with both requesters pending.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_ctl   = `ALU_SUB;
        req1_a     = 32'd3;
        req1_b     = 32'd10;
        #1;
        check("sub_req1_ready", {31'd0, req1_ready}, 32'd1);
        check("sub_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("sub_alu_ctl", {28'd0, alu_ctl}, {28'd0, `ALU_SUB});
        step();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_ctl   = `ALU_ADD;
        req0_a     = 32'd2;
        req0_b     = 32'd2;
        req1_ctl   = `ALU_SUB;
        req1_a     = 32'd100;
        req1_b     = 32'd1;
        #1;
        check("hold_alu_a_zero", alu_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_id", {31'd0, rsp_id}, 32'd1);
            check("hold_rsp_result", rsp_result, 32'hFFFF_FFF9);
            check("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
            check("hold_req1_ready", {31'd0, req1_ready}, 32'd0);
            step();
            #1;
        end

        // Release: drain and refill together; then the tie pattern under continuous load.
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_w = rr ? (i % 2) : 0;
            check("tie_req0_ready", {31'd0, req0_ready}, (exp_w == 0) ? 32'd1 : 32'd0);
            check("tie_req1_ready", {31'd0, req1_ready}, (exp_w == 1) ? 32'd1 : 32'd0);
            step();
            check("tie_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("tie_rsp_id", {31'd0, rsp_id}, exp_w[31:0]);
            check("tie_rsp_result", rsp_result, (exp_w == 1) ? 32'd99 : 32'd4);
        end

        // Grant req0 (ADD 5+7), stall, then reset while the result is held.
        req1_valid = 1'b0;
        req0_ctl   = `ALU_ADD;
        req0_a     = 32'd5;
        req0_b     = 32'd7;
        #1;
        check("pre_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
        step();
        rsp_ready = 1'b0;
        step();
        check("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("pre_rst_rsp_result", rsp_result, 32'd12);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_result", rsp_result, 32'd0);
        check("midrst_req0_ready", {31'd0, req0_ready}, 32'd0);
        step();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_ctl   = `ALU_SUB;
        req0_a     = 32'd9;
        req0_b     = 32'd4;
        #1;
        check("postrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("postrst_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("postrst_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        check("postrst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("postrst_rsp_result", rsp_result, 32'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits.
REQ-002 Parameter CTL_W, default `ALU_CTL_WIDTH, ALU control-code width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 granted this cycle.
REQ-007 req0_ctl / req0_a / req0_b  input  CTL_W / XLEN / XLEN  requester 0 ALU code and operands.
REQ-008 req1_valid, req1_ready, req1_ctl, req1_a, req1_b  same as REQ-005..007, for requester 1.
REQ-009 alu_ctl / alu_a / alu_b  output  CTL_W / XLEN / XLEN  drive to the shared combinational ALU.
REQ-010 alu_result  input  XLEN  shared ALU result, same-cycle function of alu_ctl/alu_a/alu_b.
REQ-011 rsp_valid  output  1  registered result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_id  output  1  requester index owning rsp_result.
REQ-014 rsp_result  output  XLEN  registered ALU result.

Function
REQ-015 Transfer on a request port when valid and ready are both high in the same cycle; on the response port when rsp_valid and rsp_ready are both high.
REQ-016 Output slot is free when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle (drain-and-refill).
REQ-017 The block grants at most one requester per cycle, and only when the slot is free.
REQ-018 reqN_ready is a combinational function of the valids, the slot state and the priority pointer; it does not depend on reqN_ctl/a/b.
REQ-019 With one valid requester and a free slot, that requester is granted.
REQ-020 With both valid, the requester not granted most recently wins (round robin, pointer last_grant).
REQ-021 last_grant updates only on a grant; it holds across idle cycles.
REQ-022 During a grant, alu_ctl/alu_a/alu_b equal the winner's fields; otherwise they drive all zeros.
REQ-023 On a grant edge: rsp_result<=alu_result, rsp_id<=winner, rsp_valid<=1. Latency is request transfer to rsp_valid = 1 cycle.
REQ-024 On a response transfer without a new grant, rsp_valid<=0; rsp_result and rsp_id hold their values.
REQ-025 While rsp_valid=1 and rsp_ready=0, rsp_valid/rsp_id/rsp_result hold stable and both reqN_ready are 0.
REQ-026 Sustained throughput is one operation per cycle when rsp_ready is held at 1.
REQ-027 A requester deasserting valid without a grant is legal; nothing is recorded for it.

Reset
REQ-028 While rst=1: rsp_valid=0, rsp_id=0, rsp_result=0, last_grant=1 (requester 0 wins the first tie), req0_ready=req1_ready=0.
REQ-029 Reset asserted mid-operation discards any held result without emitting it.
REQ-030 First grant is possible in the first cycle after rst deasserts.

Configuration
REQ-031 Macro ALU_ARB_RR_EN.
- Defined: round-robin arbitration per REQ-020/021.
- Undefined: fixed priority, requester 0 always wins a tie, and no last_grant state exists.
- All other requirements are unchanged in both builds.

Verification
REQ-032 Reset, then req0 only: ctl=`ALU_ADD, a=5, b=7, rsp_ready=1 -> req0_ready=1 in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_result=12.
REQ-033 Both valid every cycle, rsp_ready=1, RR build -> grants alternate 0,1,0,1; fixed build -> grants 0,0,0,0.
REQ-034 Grant to req1 (`ALU_SUB, 3, 10), then rsp_ready=0 for 3 cycles with both valid -> rsp_result=0xFFFFFFF9 and rsp_id=1 held; both ready=0; release -> a new grant occurs in the same cycle as the drain.
REQ-035 Back-to-back req0 `ALU_SLL (1, 4) then `ALU_SLT (0xFFFFFFFF, 0), rsp_ready=1 -> consecutive rsp_result 16 then 1, no bubble.
REQ-036 Assert rst while rsp_valid=1 with rsp_ready=0 -> rsp_valid=0 immediately; after release, a tie grants req0.
